// File: rtl/scan_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : scan_seq_pkg
// Brief    : Shared state encoding and default sizing for the scan sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package scan_seq_pkg;

    localparam int c_DEF_NUM_CHAINS   = 4;
    localparam int c_DEF_CHAIN_LEN    = 16;
    localparam int c_DEF_NUM_PATTERNS = 8;
    localparam int c_DEF_CNT_W        = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_SHIFT   = 3'd3,
        ST_FLUSH   = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    // Index width that never collapses to zero bits for degenerate sizes.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : scan_seq_pkg
`default_nettype wire

// File: rtl/scan_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : scan_seq_if
// Brief    : Pattern stream and scan-chain bundle between source, sequencer and core.
// Revision : 1.0 - initial release
// ============================================================================
interface scan_seq_if
    import scan_seq_pkg::*;
#(
    parameter int NUM_CHAINS = c_DEF_NUM_CHAINS
);

    logic                  pat_valid;
    logic                  pat_ready;
    logic [NUM_CHAINS-1:0] pat_si;
    logic [NUM_CHAINS-1:0] pat_exp;
    logic [NUM_CHAINS-1:0] pat_mask;
    logic [NUM_CHAINS-1:0] scan_out;
    logic [NUM_CHAINS-1:0] scan_in;
    logic                  scan_en;
    logic                  chain_clk_en;

    // Pattern source plus core-under-test side.
    modport master (
        output pat_valid,
        output pat_si,
        output pat_exp,
        output pat_mask,
        output scan_out,
        input  pat_ready,
        input  scan_in,
        input  scan_en,
        input  chain_clk_en
    );

    // Sequencer side.
    modport slave (
        input  pat_valid,
        input  pat_si,
        input  pat_exp,
        input  pat_mask,
        input  scan_out,
        output pat_ready,
        output scan_in,
        output scan_en,
        output chain_clk_en
    );

endinterface : scan_seq_if
`default_nettype wire

// File: rtl/scan_seq_cmp.sv
`default_nettype none
// ============================================================================
// Module   : scan_cmp
// Brief    : Masked unload compare, saturating fail counter, first-fail capture.
// Revision : 1.0 - initial release
// ============================================================================
module scan_cmp
    import scan_seq_pkg::*;
#(
    parameter int NUM_CHAINS = c_DEF_NUM_CHAINS,
    parameter int CNT_W      = c_DEF_CNT_W,
    parameter int PAT_W      = 3,
    parameter int BIT_W      = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  cmp_en,
    input  logic [NUM_CHAINS-1:0] scan_out,
    input  logic [NUM_CHAINS-1:0] pat_exp,
    input  logic [NUM_CHAINS-1:0] pat_mask,
    input  logic [PAT_W-1:0]      pat_idx,
    input  logic [BIT_W-1:0]      bit_idx,
    output logic [CNT_W-1:0]      fail_cnt,
    output logic                  fail_seen,
    output logic [PAT_W-1:0]      first_fail_pat,
    output logic [BIT_W-1:0]      first_fail_bit
);

    logic [NUM_CHAINS-1:0] w_mismatch;
    logic                  w_fail;

    logic [CNT_W-1:0]      r_fail_cnt;
    logic                  r_fail_seen;
    logic [PAT_W-1:0]      r_first_pat;
    logic [BIT_W-1:0]      r_first_bit;

    assign w_mismatch = (scan_out ^ pat_exp) & ~pat_mask;
    assign w_fail     = cmp_en && (|w_mismatch);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fail_cnt  <= '0;
            r_fail_seen <= 1'b0;
            r_first_pat <= '0;
            r_first_bit <= '0;
        end else if (clear) begin
            r_fail_cnt  <= '0;
            r_fail_seen <= 1'b0;
            r_first_pat <= '0;
            r_first_bit <= '0;
        end else if (w_fail) begin
            if (r_fail_cnt != {CNT_W{1'b1}}) begin
                r_fail_cnt <= r_fail_cnt + CNT_W'(1);
            end
            // Only the earliest failing beat of the run is recorded.
            if (!r_fail_seen) begin
                r_fail_seen <= 1'b1;
                r_first_pat <= pat_idx;
                r_first_bit <= bit_idx;
            end
        end
    end

    assign fail_cnt       = r_fail_cnt;
    assign fail_seen      = r_fail_seen;
    assign first_fail_pat = r_first_pat;
    assign first_fail_bit = r_first_bit;

endmodule : scan_cmp
`default_nettype wire

// File: rtl/scan_seq.sv
`default_nettype none
// ============================================================================
// Module   : scan_seq
// Brief    : Scan test sequencer: load, capture, shift/compare, flush per run.
// Revision : 1.0 - initial release
// ============================================================================
module scan_seq
    import scan_seq_pkg::*;
#(
    parameter  int NUM_CHAINS   = c_DEF_NUM_CHAINS,
    parameter  int CHAIN_LEN    = c_DEF_CHAIN_LEN,
    parameter  int NUM_PATTERNS = c_DEF_NUM_PATTERNS,
    parameter  int CNT_W        = c_DEF_CNT_W,
    localparam int PAT_W        = idx_width(NUM_PATTERNS),
    localparam int BIT_W        = idx_width(CHAIN_LEN)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    scan_seq_if.slave        bus,
    output logic             test_mode,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [PAT_W-1:0] first_fail_pat,
    output logic [BIT_W-1:0] first_fail_bit,
    output logic             fail_seen
);

    // Pattern counter must be able to hold NUM_PATTERNS itself.
    localparam int c_PCNT_W = $clog2(NUM_PATTERNS + 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [c_PCNT_W-1:0]   r_pat_cnt;
    logic [BIT_W-1:0]      r_bit_cnt;

    logic                  w_shift_st;
    logic                  w_beat;
    logic                  w_last_bit;
    logic                  w_start;
    logic                  w_abort;
    logic                  w_cmp_en;
    logic [c_PCNT_W-1:0]   w_pat_inc;
    logic [c_PCNT_W-1:0]   w_pat_prev;
    logic [PAT_W-1:0]      w_pat_idx;

    assign w_start    = start && (r_state == ST_IDLE);
    assign w_abort    = abort && (r_state != ST_IDLE);
    assign w_last_bit = (r_bit_cnt == BIT_W'(CHAIN_LEN - 1));
    assign w_pat_inc  = r_pat_cnt + c_PCNT_W'(1);
    assign w_pat_prev = r_pat_cnt - c_PCNT_W'(1);
    assign w_pat_idx  = PAT_W'(w_pat_prev);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_shift_st       = 1'b0;
        w_beat           = 1'b0;
        w_cmp_en         = 1'b0;
        w_state_nxt      = r_state;
        bus.pat_ready    = 1'b0;
        bus.scan_en      = 1'b0;
        bus.scan_in      = '0;
        bus.chain_clk_en = 1'b0;
        busy             = (r_state != ST_IDLE);
        test_mode        = (r_state != ST_IDLE);
        done             = (r_state == ST_DONE);

        w_shift_st = (r_state == ST_LOAD) || (r_state == ST_SHIFT) ||
                     (r_state == ST_FLUSH);

        // Abort wins over a beat: the handshake is withheld that cycle.
        bus.pat_ready    = w_shift_st && !abort;
        w_beat           = bus.pat_valid && bus.pat_ready;
        w_cmp_en         = w_beat && ((r_state == ST_SHIFT) || (r_state == ST_FLUSH));
        bus.scan_en      = w_shift_st;
        bus.chain_clk_en = w_beat || (r_state == ST_CAPTURE);
        if ((r_state == ST_LOAD) || (r_state == ST_SHIFT)) begin
            bus.scan_in = bus.pat_si;
        end

        if (w_abort) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        w_state_nxt = ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (w_beat && w_last_bit) begin
                        w_state_nxt = ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    w_state_nxt = (w_pat_inc < c_PCNT_W'(NUM_PATTERNS)) ? ST_SHIFT : ST_FLUSH;
                end
                ST_SHIFT: begin
                    if (w_beat && w_last_bit) begin
                        w_state_nxt = ST_CAPTURE;
                    end
                end
                ST_FLUSH: begin
                    if (w_beat && w_last_bit) begin
                        w_state_nxt = ST_DONE;
                    end
                end
                ST_DONE: begin
                    w_state_nxt = ST_IDLE;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pat_cnt <= '0;
            r_bit_cnt <= '0;
        end else if (w_start) begin
            r_pat_cnt <= '0;
            r_bit_cnt <= '0;
        end else if (!w_abort) begin
            if (w_beat) begin
                r_bit_cnt <= w_last_bit ? '0 : (r_bit_cnt + BIT_W'(1));
            end
            if (r_state == ST_CAPTURE) begin
                r_pat_cnt <= w_pat_inc;
            end
        end
    end

    // During unload, pat_cnt already points one past the pattern being unloaded.
    scan_cmp #(
        .NUM_CHAINS (NUM_CHAINS),
        .CNT_W      (CNT_W),
        .PAT_W      (PAT_W),
        .BIT_W      (BIT_W)
    ) u_cmp (
        .clk            (clk),
        .reset          (reset),
        .clear          (w_start),
        .cmp_en         (w_cmp_en),
        .scan_out       (bus.scan_out),
        .pat_exp        (bus.pat_exp),
        .pat_mask       (bus.pat_mask),
        .pat_idx        (w_pat_idx),
        .bit_idx        (r_bit_cnt),
        .fail_cnt       (fail_cnt),
        .fail_seen      (fail_seen),
        .first_fail_pat (first_fail_pat),
        .first_fail_bit (first_fail_bit)
    );

endmodule : scan_seq
`default_nettype wire

// File: doc/scan_seq.md
SCAN_SEQ -- requirements
Module: scan_seq

Interface
REQ-001 Parameters SHALL be: NUM_CHAINS, default 4, number of parallel scan chains; CHAIN_LEN, default 16, flops per chain; NUM_PATTERNS, default 8, patterns per run; CNT_W, default 16, fail counter width.
REQ-002 Ports SHALL be, clock and reset first:
clk  in  1  single clock; all logic on rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle run request; ignored unless IDLE
abort  in  1  synchronous run cancel
pat_valid  in  1  beat available
pat_ready  out  1  beat accepted when valid&ready
pat_si  in  NUM_CHAINS  stimulus bit per chain
pat_exp  in  NUM_CHAINS  expected unload bit per chain, previous pattern
pat_mask  in  NUM_CHAINS  1 = don't-care bit
scan_out  in  NUM_CHAINS  chain outputs from the core under test
scan_in  out  NUM_CHAINS  chain inputs to the core
scan_en  out  1  shift (1) / capture (0) select
chain_clk_en  out  1  core clock enable; high only on shift beats and capture
test_mode  out  1  high whenever not IDLE
busy  out  1  high whenever not IDLE
done  out  1  one-cycle end-of-run pulse
fail_cnt  out  CNT_W  failing beats, saturating
first_fail_pat  out  clog2(NUM_PATTERNS)  pattern index of first failure
first_fail_bit  out  clog2(CHAIN_LEN)  beat index of first failure
fail_seen  out  1  at least one failure this run

Function
REQ-003 States SHALL be IDLE, LOAD, CAPTURE, SHIFT, FLUSH, DONE.
REQ-004 IDLE + start SHALL go to LOAD, clearing pat_cnt, bit_cnt, fail_cnt, fail_seen, first_fail_*.
REQ-005 A beat SHALL be one cycle with pat_valid&pat_ready; pat_ready=1 only in LOAD, SHIFT and FLUSH.
REQ-006 On each beat, bit_cnt SHALL increment; beat CHAIN_LEN-1 SHALL wrap bit_cnt to 0 and exit the state.
REQ-007 With pat_valid=0, chain_clk_en SHALL be 0 and scan_en SHALL hold 1, so the chains freeze (stall).
REQ-008 scan_in SHALL equal pat_si in LOAD/SHIFT and all-zero otherwise; scan_en=1 in LOAD/SHIFT/FLUSH, else 0.
REQ-009 LOAD end SHALL go to CAPTURE; LOAD beats SHALL NOT be compared.
REQ-010 CAPTURE SHALL last exactly one cycle with scan_en=0, chain_clk_en=1, and SHALL increment pat_cnt; it SHALL go to SHIFT if the new pat_cnt<NUM_PATTERNS, else to FLUSH.
REQ-011 On each SHIFT/FLUSH beat, mismatch=(scan_out^pat_exp)&~pat_mask; a nonzero mismatch SHALL increment fail_cnt by 1, saturating at all-ones.
REQ-012 On the first failing beat of a run, first_fail_pat SHALL be set to pat_cnt-1, first_fail_bit to bit_cnt, and fail_seen to 1; later failures SHALL NOT change them.
REQ-013 FLUSH end SHALL go to DONE; DONE SHALL assert done for one cycle, then go to IDLE.
REQ-014 Results SHALL hold until the next start.
REQ-015 abort in any non-IDLE state SHALL go to IDLE next cycle, with no done pulse and results held.
REQ-016 abort SHALL take priority over a beat in the same cycle; start while busy SHALL be ignored.

Reset
REQ-017 reset low SHALL immediately force IDLE; pat_ready, scan_en, chain_clk_en, test_mode, busy, done and fail_seen to 0; scan_in, fail_cnt and first_fail_* to 0.
REQ-018 Reset mid-run SHALL discard the run; no done pulse after release.

Structure
REQ-019 Package scan_seq_pkg SHALL hold the state enum and the default parameter constants.
REQ-020 Sub-module scan_cmp SHALL implement the masked compare and first-fail capture.

Verification
REQ-021 Defaults, loopback core model, pat_exp equal to the loaded stimulus, valid always high -> done at cycle 1+16+(16+1)*8 after start; fail_cnt=0.
REQ-022 Flip chain 2 output at pattern 3, beat 5 -> fail_cnt=1, first_fail_pat=3, first_fail_bit=5.
REQ-023 Same flipped bit with pat_mask[2]=1 on that beat -> fail_cnt=0, fail_seen=0.
REQ-024 Random pat_valid gaps -> chain_clk_en low during every gap; results match the no-gap run.
REQ-025 CNT_W=2 with every beat failing -> fail_cnt saturates at 3.
REQ-026 abort mid-SHIFT, then a reset pulse mid-LOAD -> IDLE, no done, outputs match REQ-017; a fresh start then passes.
